// File: rtl/wb_select_unit.sv
// wb_select_unit: registers the ALU/shifter/HI/LO writeback result, owns HI/LO and a shift-add MULTU unit.
module wb_select_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             out_illegal,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_ADD = 6'b100000, F_SUB = 6'b100010,
                         F_SLT = 6'b101010, F_SLL = 6'b000000, F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                         F_MULTU = 6'b011001;
  logic [WIDTH-1:0] data_q, data_d, hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, mplier_q, mplier_d, sel;
  logic [2*WIDTH:0] acc_q, acc_d, acc_sh;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_nx;
  logic             valid_q, valid_d, illegal_q, illegal_d, busy_q, busy_d;
  logic             accept, is_mul, is_alu, known, start, done;
  always_comb begin
    accept    = in_valid && !busy_q;
    is_mul    = funct == F_MULTU;
    is_alu    = funct inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT};
    known     = is_alu || funct inside {F_SLL, F_MFHI, F_MFLO};
    start     = accept && is_mul;
    sel       = is_alu ? alu_out : funct == F_SLL ? shift_out :
                funct == F_MFHI ? hi_q : funct == F_MFLO ? lo_q : '0;
    data_d    = accept && !is_mul ? sel : data_q;
    valid_d   = accept && !is_mul;
    illegal_d = accept && !is_mul && !known;
    // carry out of the upper-half add lands in bit 2*WIDTH before the shift
    sum       = acc_q[2*WIDTH:WIDTH] + {1'b0, mplier_q[0] ? mcand_q : '0};
    acc_sh    = {sum, acc_q[WIDTH-1:0]} >> 1;
    cnt_nx    = cnt_q - CW'(1);
    done      = busy_q && cnt_nx == '0;
    mcand_d   = start ? src_a : mcand_q;
    mplier_d  = start ? src_b : busy_q ? mplier_q >> 1 : mplier_q;
    acc_d     = start ? '0 : busy_q ? acc_sh : acc_q;
    cnt_d     = start ? CW'(WIDTH) : busy_q ? cnt_nx : cnt_q;
    busy_d    = start ? 1'b1 : done ? 1'b0 : busy_q;
    hi_d      = done ? acc_sh[2*WIDTH-1:WIDTH] : hi_q;
    lo_d      = done ? acc_sh[WIDTH-1:0] : lo_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
    end
  end
  assign in_ready    = !busy_q;
  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign out_illegal = illegal_q;
  assign data_out    = data_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
endmodule

// File: tb/tb_wb_select_unit.sv
// tb_wb_select_unit: directed checks plus a per-cycle behavioural model of the 32-bit unit.
module tb_wb_select_unit;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_ADD = 6'b100000, F_SUB = 6'b100010,
                         F_SLT = 6'b101010, F_SLL = 6'b000000, F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                         F_MULTU = 6'b011001;
  logic        clk, reset, in_valid, in_ready, out_valid, out_illegal, busy;
  logic [5:0]  funct;
  logic [31:0] alu_out, shift_out, src_a, src_b, data_out, hi_out, lo_out;
  logic        in_valid8, in_ready8, out_valid8, out_illegal8, busy8;
  logic [5:0]  funct8;
  logic [7:0]  src_a8, src_b8, data_out8, hi_out8, lo_out8;
  int          n_pass = 0, n_total = 0;
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_data = 0;
  logic        m_valid = 0, m_ill = 0;
  logic [63:0] m_prod = 0;

  wb_select_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
    .alu_out(alu_out), .shift_out(shift_out), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .data_out(data_out), .out_illegal(out_illegal), .busy(busy),
    .hi_out(hi_out), .lo_out(lo_out));

  wb_select_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .funct(funct8),
    .alu_out(8'h00), .shift_out(8'h00), .src_a(src_a8), .src_b(src_b8),
    .out_valid(out_valid8), .data_out(data_out8), .out_illegal(out_illegal8), .busy(busy8),
    .hi_out(hi_out8), .lo_out(lo_out8));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: multiply by arithmetic, occupancy as a plain countdown of remaining busy cycles.
  always begin
    @(posedge clk);
    if (reset) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_data = 0; m_valid = 0; m_ill = 0;
    end else begin
      automatic bit acc = in_valid && m_left == 0;
      m_valid = 0;
      m_ill = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) {m_hi, m_lo} = m_prod;
      end
      if (acc) begin
        if (funct == F_MULTU) begin
          m_prod = 64'(src_a) * 64'(src_b);
          m_left = 32;
        end else begin
          m_valid = 1;
          case (funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: m_data = alu_out;
            F_SLL:  m_data = shift_out;
            F_MFHI: m_data = m_hi;
            F_MFLO: m_data = m_lo;
            default: begin m_data = 0; m_ill = 1; end
          endcase
        end
      end
    end
    #1;
    chk("m_data", data_out, m_data);
    chk("m_valid", out_valid, m_valid);
    chk("m_illegal", out_illegal, m_ill);
    chk("m_busy", busy, m_left > 0);
    chk("m_ready", in_ready, m_left == 0);
    chk("m_hi", hi_out, m_hi);
    chk("m_lo", lo_out, m_lo);
  end

  task automatic drive(input logic [5:0] f, input logic [31:0] alu, input logic [31:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1; funct = f; alu_out = alu; shift_out = sh; src_a = a; src_b = b;
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1; in_valid = 0; funct = 0; alu_out = 0; shift_out = 0; src_a = 0; src_b = 0;
    in_valid8 = 0; funct8 = 0; src_a8 = 0; src_b8 = 0;
    @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_hilo", {hi_out, lo_out}, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    drive(F_ADD, 32'h5, 0, 0, 0);
    chk("add_data", data_out, 32'h5);
    chk("add_valid", out_valid, 1);
    drive(F_AND, 32'hF0F0_F0F0, 0, 0, 0);
    chk("and_data", data_out, 32'hF0F0_F0F0);
    chk("and_valid", {out_valid, out_illegal}, 2'b10);
    drive(F_SLL, 0, 32'h8000_0000, 0, 0);
    chk("sll_data", {out_illegal, data_out}, {1'b0, 32'h8000_0000});
    drive(6'b111111, 32'h1234, 32'h5678, 0, 0);
    chk("ill_data", {out_valid, out_illegal, data_out}, {2'b11, 32'h0});
    in_valid = 0;
    @(negedge clk);
    chk("ill_once", {out_valid, out_illegal}, 2'b00);
    chk("hold_data", data_out, 0);
    drive(F_MULTU, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    in_valid = 0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("mul_busy_cycles", n, 32);
    chk("mul_hi", hi_out, 32'hFFFF_FFFE);
    chk("mul_lo", lo_out, 32'h0000_0001);
    drive(F_MULTU, 0, 0, 32'd7, 32'd6);
    funct = F_MFHI;
    chk("stall_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 100) begin n++; @(negedge clk); end
    chk("mfhi_edge", n, 33);
    chk("mfhi_data", data_out, 0);
    funct = F_MFLO;
    @(negedge clk);
    chk("mflo_data", data_out, 32'h2A);
    drive(F_MULTU, 0, 0, 32'h1234, 32'h5678);
    in_valid = 0;
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi_out, lo_out}, 0);
    chk("abort_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    drive(F_ADD, 32'h77, 0, 0, 0);
    chk("post_abort_add", {out_valid, data_out}, {1'b1, 32'h77});
    in_valid = 0;
    in_valid8 = 1; funct8 = F_MULTU; src_a8 = 8'hFF; src_b8 = 8'h02;
    @(negedge clk);
    in_valid8 = 0;
    n = 0;
    while (busy8 && n < 100) begin n++; @(negedge clk); end
    chk("w8_busy_cycles", n, 8);
    chk("w8_hi", hi_out8, 8'h01);
    chk("w8_lo", lo_out8, 8'hFE);
    chk("w8_no_valid", out_valid8, 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wb_select_unit.md
# wb_select_unit

Parametrised writeback-select stage for the CO datapath. It registers the selected result from the ALU, shifter or HI/LO registers onto a single writeback bus, qualified by a valid strobe. It also owns the HI/LO register pair and a multi-cycle shift-add unsigned multiplier for MULTU. It sits between the execute units (ALU, shifter) and the register-file write port, and accepts one operation at a time through a valid/ready handshake.

## Interface
- WIDTH, 32, datapath width in bits; legal values are WIDTH ≥ 2. HI and LO are each WIDTH bits wide.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation present on funct and the operand inputs
- in_ready  output  1  unit can accept an operation; combinational, equal to !busy
- funct  input  6  MIPS funct code that selects the operation
- alu_out  input  WIDTH  ALU result
- shift_out  input  WIDTH  shifter result
- src_a  input  WIDTH  MULTU multiplicand
- src_b  input  WIDTH  MULTU multiplier
- out_valid  output  1  single-cycle strobe: data_out is a new writeback value
- data_out  output  WIDTH  registered writeback data
- out_illegal  output  1  qualifies out_valid; the accepted funct was not recognised
- busy  output  1  multiplier is running
- hi_out, lo_out  output  WIDTH each  current HI and LO register contents

## Operation
- An operation is accepted at a rising edge where in_valid && in_ready. When in_valid is high while busy is high, the operation is not accepted and nothing changes; the source must hold its inputs.
- Funct decode applied at the accepting edge:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010: data_out ← alu_out, out_valid ← 1.
  - SLL 000000: data_out ← shift_out, out_valid ← 1.
  - MFHI 010000: data_out ← HI. MFLO 010010: data_out ← LO. Both set out_valid ← 1.
  - MULTU 011001: capture src_a and src_b, clear the internal 2·WIDTH accumulator, load the step counter with WIDTH, set busy ← 1. No out_valid is produced; MULTU has no register-file writeback.
  - Any other funct: data_out ← 0, out_valid ← 1, out_illegal ← 1.
- out_valid and out_illegal are high for exactly one cycle per accepted non-MULTU operation. data_out holds its last value until the next accepted non-MULTU operation.
- Multiplier behaviour, one step per edge while busy:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator, keeping the carry in bit 2·WIDTH.
  - Shift the accumulator and the multiplier right by 1, then decrement the counter.
  - The result is exact unsigned arithmetic, {HI,LO} = src_a × src_b; no bits are truncated.
- At the step where the counter reaches 0, HI ← accumulator[2W−1:W], LO ← accumulator[W−1:0] and busy ← 0, all at the same edge.
- HI and LO change only at MULTU completion or at reset. hi_out and lo_out show the registers directly.
- Reset asserted at any time, including mid-multiply: the multiply is aborted and no partial result reaches HI or LO.
- Reset values: data_out = 0, out_valid = 0, out_illegal = 0, busy = 0, HI = 0, LO = 0, counter = 0. in_ready is therefore 1 during and after reset.

## Timing
- Single-cycle operations:
  - Accepted at edge E; data_out, out_valid and out_illegal update at edge E.
  - They are visible in the cycle E→E+1.
  - Back-to-back acceptance at every edge is supported.
- MULTU:
  - Accepted at edge E; busy is high from after E.
  - Steps occur at edges E+1 … E+WIDTH.
  - HI/LO are written and busy falls at edge E+WIDTH, and in_ready is high again after E+WIDTH.
  - Occupancy is WIDTH+1 cycles including the accept cycle.
- MFHI/MFLO:
  - They cannot overtake a running MULTU, because the stall guarantees ordering.
  - The earliest one can be accepted is edge E+WIDTH+1, and it returns the new HI/LO value.
- out_valid is never asserted at an edge where busy is high.

## Test plan
- Reset, then ADD with alu_out=0x0000_0005 and AND with alu_out=0xF0F0_F0F0 at consecutive edges → data_out is 0x5 then 0xF0F0_F0F0, out_valid is high for 2 consecutive cycles, out_illegal is 0.
- SLL with shift_out=0x8000_0000, then funct=111111 → data_out is 0x8000_0000 (illegal 0), then data_out is 0 with out_illegal=1 for one cycle.
- MULTU with src_a=0xFFFF_FFFF and src_b=0xFFFF_FFFF (WIDTH=32) → busy is high for 32 cycles; then HI=0xFFFF_FFFE and LO=0x0000_0001; out_valid stays 0 throughout.
- MFHI held on in_valid from the cycle after a MULTU of 7×6 is accepted → in_ready=0 while busy; MFHI is accepted at edge E+33; data_out=0 (HI), and a following MFLO gives data_out=0x2A.
- Reset pulsed at step 10 of a MULTU of 0x1234×0x5678 → busy=0, HI=LO=0, in_ready=1 immediately; the next ADD is accepted normally.
- WIDTH=8 instance, MULTU 0xFF×0x02 → busy for 8 cycles; then HI=0x01, LO=0xFE.
